corr_feeder: RTL and testbench

Sequencing front-end that sits directly upstream of the time-multiplexed correlator blocks. It captures one 12-antenna sample (real and imaginary bits) per input strobe and holds it stable while it issues 12 consecutive `en` cycles, one per correlator pair slot. It also counts samples into integration blocks and pulses `sw` on the last slot of each block, so the correlators switch accumulator banks on an exact block boundary. Overrun detection covers samples that arrive faster than one per 12 `clk_x` cycles.

---
 rtl/corr_feeder.sv | 193 +++++++++++++++++++
 tb/tb_corr_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_feeder.sv
// corr_feeder: sequencing front-end for the time-multiplexed correlators.
// It captures one 12-antenna sample (real and imaginary sign bits) per strobe.
// It then holds that sample on re/im for SLOTS consecutive en cycles.
// Samples are counted into integration blocks. sw pulses on the final slot of
// each block, so the correlators switch accumulator banks exactly on a block
// boundary.
//
// Configuration macro:
//   CORR_FEEDER_DEPTH2_EN - pending store is a 2-entry FIFO
//                           (default: a single pending register)
//
// Ports:
//   clk_x      in   correlator clock (only clock)
//   rst        in   synchronous active-high reset
//   valid_i    in   one-cycle strobe; new sample on re_i/im_i
//   re_i/im_i  in   antenna real/imag sign bits
//   block_size in   samples per integration block (0 behaves as 1)
//   clear_ov   in   clears overrun
//   en         out  slot-valid to correlators
//   re/im      out  held sample to correlators
//   sw         out  bank-switch pulse, aligned with the last en of a block
//   busy       out  a sample is being sequenced (equals en)
//   overrun    out  sticky: a sample was dropped
//   blocks     out  completed-block counter, wraps
module corr_feeder #(
   parameter int COUNT  = 24,
   parameter int BCOUNT = 16,
   parameter int SLOTS  = 12,
   parameter int DELAY  = 3
) (
   input  logic              clk_x,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [11:0]       re_i,
   input  logic [11:0]       im_i,
   input  logic [COUNT-1:0]  block_size,
   input  logic              clear_ov,
   output logic              en,
   output logic [11:0]       re,
   output logic [11:0]       im,
   output logic              sw,
   output logic              busy,
   output logic              overrun,
   output logic [BCOUNT-1:0] blocks
);

`ifdef CORR_FEEDER_DEPTH2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int SW = $clog2(SLOTS);

   // DELAY only shapes simulation models of the register path; it has no
   // effect on the synthesized logic.
   if (DELAY > 0) begin : g_dly
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [COUNT-1:0]    scnt_q, scnt_d;
   logic [COUNT-1:0]    bsz_q, bsz_d;
   logic [BCOUNT-1:0]   blocks_q, blocks_d;
   logic [23:0]         cur_q, cur_d;      // {re, im}
   logic [23:0]         pend0_q, pend0_d;  // FIFO head
   logic [23:0]         pend1_q, pend1_d;
   logic [1:0]          pcnt_q, pcnt_d;
   logic                ov_q, ov_d;
   logic                sw_q, sw_d;

   logic                last, nonempty, full, pop, push, load, drop;
   logic [23:0]         load_data;
   logic [1:0]          pc;

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      scnt_d    = scnt_q;
      bsz_d     = bsz_q;
      blocks_d  = blocks_q;
      cur_d     = cur_q;
      pend0_d   = pend0_q;
      pend1_d   = pend1_q;
      pcnt_d    = pcnt_q;
      ov_d      = ov_q;
      pop       = 1'b0;
      push      = 1'b0;
      load      = 1'b0;
      drop      = 1'b0;
      load_data = {re_i, im_i};
      pc        = pcnt_q;

      last     = (state_q == RUN) && (slot_q == SW'(SLOTS - 1));
      nonempty = (pcnt_q != 2'd0);
      full     = (pcnt_q == 2'(DEPTH));

      // Queued samples go first; a simultaneous strobe is queued behind them.
      if (state_q == IDLE || last) begin
         if (nonempty) begin
            pop       = 1'b1;
            load      = 1'b1;
            load_data = pend0_q;
            push      = valid_i;
         end else if (valid_i) begin
            load = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end else if (valid_i) begin
         if (full) drop = 1'b1;
         else      push = 1'b1;
      end

      // Block accounting at the completion of the final slot.
      if (last) begin
         if (scnt_q == bsz_q - COUNT'(1)) begin
            scnt_d   = '0;
            blocks_d = blocks_q + BCOUNT'(1);
         end else begin
            scnt_d = scnt_q + COUNT'(1);
         end
      end

      if (load) begin
         state_d = RUN;
         slot_d  = '0;
         cur_d   = load_data;
         // Block size only changes at the start of a block.
         if (scnt_d == '0)
            bsz_d = (block_size == '0) ? COUNT'(1) : block_size;
      end else if (state_q == RUN) begin
         slot_d = slot_q + SW'(1);
      end

      // Pop before push so a full store that pops still accepts a sample.
      if (pop) begin
         pend0_d = pend1_q;
         pc      = pc - 2'd1;
      end
      if (push) begin
         if (pc == 2'd0) pend0_d = {re_i, im_i};
         else            pend1_d = {re_i, im_i};
         pc = pc + 2'd1;
      end
      pcnt_d = pc;

      if (drop)          ov_d = 1'b1;
      else if (clear_ov) ov_d = 1'b0;

      // Registered so it lines up with the en of slot SLOTS-1.
      sw_d = (state_d == RUN) && (slot_d == SW'(SLOTS - 1)) &&
             (scnt_d == bsz_d - COUNT'(1));
   end

   always_ff @(posedge clk_x) begin
      if (rst) begin
         state_q  <= IDLE;
         slot_q   <= '0;
         scnt_q   <= '0;
         bsz_q    <= COUNT'(1);
         blocks_q <= '0;
         cur_q    <= '0;
         pend0_q  <= '0;
         pend1_q  <= '0;
         pcnt_q   <= '0;
         ov_q     <= 1'b0;
         sw_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         scnt_q   <= scnt_d;
         bsz_q    <= bsz_d;
         blocks_q <= blocks_d;
         cur_q    <= cur_d;
         pend0_q  <= pend0_d;
         pend1_q  <= pend1_d;
         pcnt_q   <= pcnt_d;
         ov_q     <= ov_d;
         sw_q     <= sw_d;
      end
   end

   assign en      = (state_q == RUN);
   assign busy    = en;
   assign re      = cur_q[23:12];
   assign im      = cur_q[11:0];
   assign sw      = sw_q;
   assign overrun = ov_q;
   assign blocks  = blocks_q;

endmodule

// File: tb/tb_corr_feeder.sv
// Directed testbench for corr_feeder. Inputs change 1 time unit after each
// rising edge; outputs are sampled at that same point.
module tb_corr_feeder;
   logic        clk_x = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic [11:0] re_i = '0;
   logic [11:0] im_i = '0;
   logic [23:0] block_size = 24'd1;
   logic        clear_ov = 1'b0;
   logic        en, sw, busy, overrun;
   logic [11:0] re, im;
   logic [15:0] blocks;

   int checks = 0;
   int errors = 0;

`ifdef CORR_FEEDER_DEPTH2_EN
   localparam int BURST_N  = 3;
   localparam bit BURST_OV = 1'b0;
`else
   localparam int BURST_N  = 2;
   localparam bit BURST_OV = 1'b1;
`endif

   corr_feeder dut (
      .clk_x(clk_x), .rst(rst), .valid_i(valid_i), .re_i(re_i), .im_i(im_i),
      .block_size(block_size), .clear_ov(clear_ov), .en(en), .re(re), .im(im),
      .sw(sw), .busy(busy), .overrun(overrun), .blocks(blocks)
   );

   always #5 clk_x = ~clk_x;

   task automatic tick;
      @(posedge clk_x);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      checks++;
      if ({en, sw, busy, overrun} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got en/sw/busy/ov=%b exp 0000", {en, sw, busy, overrun});
      end
      checks++;
      if (blocks !== 16'd0 || re !== 12'd0 || im !== 12'd0) begin
         errors++;
         $display("FAIL reset_regs: got blocks=%h re=%h im=%h exp 0", blocks, re, im);
      end
   endtask

   task automatic test_single(input logic [23:0] bs);
      do_reset;
      block_size = bs;
      re_i = 12'hA5A; im_i = 12'h5A5; valid_i = 1'b1;
      tick;
      valid_i = 1'b0; re_i = '0; im_i = '0;
      for (int k = 0; k < 14; k++) begin
         checks++;
         if (en !== (k < 12) || sw !== (k == 11)) begin
            errors++;
            $display("FAIL single_en_sw bs=%0d k=%0d: got en=%b sw=%b exp en=%b sw=%b",
                     bs, k, en, sw, k < 12, k == 11);
         end
         if (k < 12) begin
            checks++;
            if (re !== 12'hA5A || im !== 12'h5A5) begin
               errors++;
               $display("FAIL single_data k=%0d: got %h/%h exp a5a/5a5", k, re, im);
            end
         end
         tick;
      end
      checks++;
      if (blocks !== 16'd1) begin
         errors++;
         $display("FAIL single_blocks bs=%0d: got %0d exp 1", bs, blocks);
      end
   endtask

   task automatic test_stream;
      logic [11:0] d;
      do_reset;
      block_size = 24'd3;
      for (int k = 0; k < 110; k++) begin
         d = 12'(12'h100 + k / 12);
         valid_i = (k % 12 == 0) && (k < 108);
         re_i = d; im_i = ~d;
         tick;
         valid_i = 1'b0;
         checks++;
         if (en !== (k < 108) || busy !== (k < 108) ||
             sw !== (k == 35 || k == 71 || k == 107)) begin
            errors++;
            $display("FAIL stream_en_sw k=%0d: got en=%b busy=%b sw=%b", k, en, busy, sw);
         end
         if (k < 108) begin
            checks++;
            if (re !== d || im !== ~d) begin
               errors++;
               $display("FAIL stream_data k=%0d: got %h/%h exp %h/%h", k, re, im, d, ~d);
            end
         end
      end
      checks++;
      if (blocks !== 16'd3 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL stream_blocks: got blocks=%0d ov=%b exp 3 0", blocks, overrun);
      end
   endtask

   task automatic test_burst;
      logic [11:0] d;
      do_reset;
      block_size = 24'd1;
      for (int k = 0; k < 40; k++) begin
         valid_i = (k < 3);
         re_i = 12'(12'h300 + k); im_i = 12'(12'h400 + k);
         tick;
         valid_i = 1'b0;
         checks++;
         if (en !== (k < BURST_N * 12)) begin
            errors++;
            $display("FAIL burst_en k=%0d: got %b exp %b", k, en, k < BURST_N * 12);
         end
         if (k < BURST_N * 12) begin
            d = 12'(12'h300 + k / 12);
            checks++;
            if (re !== d || im !== 12'(d + 12'h100)) begin
               errors++;
               $display("FAIL burst_data k=%0d: got %h/%h exp %h/%h", k, re, im, d, d + 12'h100);
            end
         end
      end
      checks++;
      if (overrun !== BURST_OV || blocks !== 16'(BURST_N)) begin
         errors++;
         $display("FAIL burst_ov: got ov=%b blocks=%0d exp %b %0d", overrun, blocks, BURST_OV, BURST_N);
      end
   endtask

   task automatic test_clear_ov;
      do_reset;
      block_size = 24'd1;
      for (int k = 0; k < 4; k++) begin
         valid_i = 1'b1; re_i = 12'(k); im_i = 12'(k);
         tick;
      end
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL ov_set: got %b exp 1", overrun);
      end
      clear_ov = 1'b1;
      tick;
      valid_i = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL ov_clear_vs_drop: got %b exp 1", overrun);
      end
      tick;
      clear_ov = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ov_clear: got %b exp 0", overrun);
      end
      for (int k = 0; k < 60; k++) tick;
   endtask

   task automatic test_bsz_change;
      do_reset;
      block_size = 24'd4;
      for (int k = 0; k < 74; k++) begin
         valid_i = (k % 12 == 0) && (k < 72);
         re_i = 12'(k); im_i = 12'(k);
         if (k == 15) block_size = 24'd2;
         tick;
         valid_i = 1'b0;
         checks++;
         if (sw !== (k == 47 || k == 71) || en !== (k < 72)) begin
            errors++;
            $display("FAIL bsz_sw k=%0d: got sw=%b en=%b exp sw=%b en=%b",
                     k, sw, en, k == 47 || k == 71, k < 72);
         end
      end
      checks++;
      if (blocks !== 16'd2) begin
         errors++;
         $display("FAIL bsz_blocks: got %0d exp 2", blocks);
      end
   endtask

   // No reset on entry: blocks is non-zero from the previous test.
   task automatic test_rst_mid;
      bit seen;
      for (int k = 0; k < 6; k++) begin
         valid_i = (k < 2);
         re_i = 12'(12'hB01 + k); im_i = 12'(12'hB01 + k);
         tick;
         valid_i = 1'b0;
      end
      checks++;
      if (en !== 1'b1 || blocks === 16'd0) begin
         errors++;
         $display("FAIL rst_pre: got en=%b blocks=%0d exp en=1 blocks!=0", en, blocks);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if ({en, sw, busy} !== 3'b0 || blocks !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid: got en/sw/busy=%b blocks=%0d exp 000 0", {en, sw, busy}, blocks);
      end
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick;
         if (en) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_pending: got en seen=%b exp 0", seen);
      end
   endtask

   initial begin
      test_reset;
      test_single(24'd1);
      test_single(24'd0);
      test_stream;
      test_burst;
      test_clear_ov;
      test_bsz_change;
      test_rst_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
